// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, start/busy/done handshake, flush abort, fast path for div-by-zero/overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [2:0]      state_o
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_sgn, b_sgn, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, quo_fix, rem_fix;
    logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        a_sgn    = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
        b_sgn    = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
        sa       = a_sgn && a_q[XLEN-1];
        sb       = b_sgn && b_q[XLEN-1];
        mag_a    = sa ? -a_q : a_q;
        mag_b    = sb ? -b_q : b_q;
        div_zero = op_q[2] && (b_q == '0);
        div_ovf  = op_q[2] && !op_q[0] && (a_q == MIN_INT) && (b_q == '1);
        // Multiplier sits in the low half of acc and shifts out as the product shifts in.
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mag_a_q & {XLEN{acc_q[0]}}};
        // Dividend sits in quo and shifts into the partial remainder MSB-first.
        rem_shift = {rem_q, quo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, mag_b_q};
        prod      = neg_q ? -acc_q : acc_q;
        quo_fix   = neg_q ? -quo_q : quo_q;
        rem_fix   = neg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = PREP;
            PREP:    state_d = (div_zero || div_ovf) ? FIX : CALC;
            CALC:    if (cnt_q == LAST_ITER) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    op_d = funct3_i;
                    a_d  = a_i;
                    b_d  = b_i;
                end
            end
            PREP: begin
                mag_a_d = mag_a;
                mag_b_d = mag_b;
                neg_d   = (op_q[2] && op_q[1]) ? sa : (sa ^ sb);
                acc_d   = {{XLEN{1'b0}}, mag_b};
                quo_d   = mag_a;
                rem_d   = '0;
                cnt_d   = '0;
                // Special cases preload the final values unsigned so FIX passes them through.
                if (div_zero) begin
                    quo_d = '1;
                    rem_d = a_q;
                    neg_d = 1'b0;
                end else if (div_ovf) begin
                    quo_d = MIN_INT;
                    rem_d = '0;
                    neg_d = 1'b0;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (!op_q[2]) begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end else if (!rem_diff[XLEN]) begin
                    rem_d = rem_diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
            end
            FIX: begin
                if (!flush_i) begin
                    if (op_q == 3'd0)  result_d = prod[XLEN-1:0];
                    else if (!op_q[2]) result_d = prod[2*XLEN-1:XLEN];
                    else if (op_q[1])  result_d = rem_fix;
                    else               result_d = quo_fix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed RV32M ops, special cases,
// handshake, flush, reset and randomised ops against a reference model.
`timescale 1ns/1ps
module tb_muldiv_unit;
    localparam int XLEN     = 32;
    localparam int LAT_NORM = XLEN + 3;
    localparam int LAT_FAST = 3;
    localparam int BUDGET   = 60;
    localparam logic [XLEN-1:0] MIN_INT = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [2:0]      funct3_i = 3'd0;
    logic [XLEN-1:0] a_i = '0;
    logic [XLEN-1:0] b_i = '0;
    logic            busy_o, done_o;
    logic [XLEN-1:0] result_o;
    logic [2:0]      state_o;

    logic [XLEN-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i),
        .funct3_i(funct3_i), .a_i(a_i), .b_i(b_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [XLEN-1:0] ref_model(input logic [2:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic [XLEN-1:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == '0) ? '1 : 32'(sa / sb);
            3'd5: r = (b == '0) ? '1 : a / b;
            3'd6: r = (b == '0) ? a : 32'(sa % sb);
            default: r = (b == '0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Called just after a negedge; start is sampled at the next posedge (E0).
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        funct3_i = op;
        a_i      = a;
        b_i      = b;
        start_i  = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Negedge i after E0 shows the value the DUT presents at edge E0+i.
    task automatic wait_done(output bit got, output int lat, output logic [XLEN-1:0] res,
                             output bit busy_gap, output bit overlap, output bit after_bad);
        got = 0; lat = 0; res = '0; busy_gap = 0; overlap = 0; after_bad = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge clk);
            if (busy_o && done_o) overlap = 1;
            if (done_o) begin
                got = 1; lat = i; res = result_o;
                break;
            end
            if (!busy_o) busy_gap = 1;
        end
        if (got) begin
            @(negedge clk);
            after_bad = done_o || busy_o;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy_o, done_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: busy/done=%b, required 00", {busy_o, done_o});
        end
        n_tests++;
        if (result_o !== '0) begin
            n_fail++; $display("FAIL reset_result: got %h, required 0", result_o);
        end
        n_tests++;
        if (state_o !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d, required 0", state_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0] op_t [4];
        logic [XLEN-1:0] a_t [4], b_t [4], e_t [4];
        bit got, busy_gap, overlap, after_bad;
        int lat;
        logic [XLEN-1:0] res, exp;
        op_t = '{3'd0, 3'd3, 3'd1, 3'd2};
        a_t  = '{32'h0000_0007, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        b_t  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        e_t  = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_q.push_back(e_t[k]);
            issue(op_t[k], a_t[k], b_t[k]);
            wait_done(got, lat, res, busy_gap, overlap, after_bad);
            exp = exp_q.pop_front();
            n_tests++;
            if (!got || lat != LAT_NORM) begin
                n_fail++; $display("FAIL mul_latency[%0d]: done=%0b at cycle %0d, required cycle %0d", k, got, lat, LAT_NORM);
            end
            n_tests++;
            if (res !== exp) begin
                n_fail++; $display("FAIL mul_result[%0d]: got %h, required %h", k, res, exp);
            end
            n_tests++;
            if ({busy_gap, overlap, after_bad} !== 3'b000) begin
                n_fail++; $display("FAIL mul_handshake[%0d]: busy_gap/overlap/after_done=%b, required 000", k, {busy_gap, overlap, after_bad});
            end
        end
    endtask

    task automatic test_div();
        logic [2:0] op_t [10];
        logic [XLEN-1:0] a_t [10], b_t [10], e_t [10];
        int l_t [10];
        bit got, busy_gap, overlap, after_bad;
        int lat;
        logic [XLEN-1:0] res, exp;
        op_t = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd4, 3'd6, 3'd5, 3'd4, 3'd6};
        a_t  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000,
                 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        b_t  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFF,
                 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        e_t  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'd0,
                 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        l_t  = '{LAT_NORM, LAT_NORM, LAT_NORM, LAT_NORM, LAT_NORM,
                 LAT_FAST, LAT_FAST, LAT_FAST, LAT_FAST, LAT_FAST};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_q.push_back(e_t[k]);
            issue(op_t[k], a_t[k], b_t[k]);
            wait_done(got, lat, res, busy_gap, overlap, after_bad);
            exp = exp_q.pop_front();
            n_tests++;
            if (!got || lat != l_t[k]) begin
                n_fail++; $display("FAIL div_latency[%0d]: done=%0b at cycle %0d, required cycle %0d", k, got, lat, l_t[k]);
            end
            n_tests++;
            if (res !== exp) begin
                n_fail++; $display("FAIL div_result[%0d]: got %h, required %h", k, res, exp);
            end
            n_tests++;
            if ({busy_gap, overlap, after_bad} !== 3'b000) begin
                n_fail++; $display("FAIL div_handshake[%0d]: busy_gap/overlap/after_done=%b, required 000", k, {busy_gap, overlap, after_bad});
            end
        end
    endtask

    task automatic test_handshake();
        bit got, stray;
        int lat;
        logic [XLEN-1:0] res, exp;
        @(negedge clk);
        exp_q.push_back(32'd14);
        issue(3'd5, 32'd100, 32'd7);
        got = 0; lat = 0; res = '0;
        for (int i = 1; i <= BUDGET && !got; i++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1; lat = i; res = result_o;
                // start during DONE with new operands must be dropped
                funct3_i = 3'd0; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1;
            end else begin
                if (i == 1) begin funct3_i = 3'd0; a_i = 32'h1234; b_i = 32'd3; end
                if (i == 4) start_i = 1'b1;
                if (i == 5) start_i = 1'b0;
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        exp = exp_q.pop_front();
        n_tests++;
        if (!got || lat != LAT_NORM) begin
            n_fail++; $display("FAIL hs_latency: done=%0b at cycle %0d, required cycle %0d", got, lat, LAT_NORM);
        end
        n_tests++;
        if (res !== exp) begin
            n_fail++; $display("FAIL hs_result: got %h, required %h", res, exp);
        end
        stray = busy_o || done_o;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_o || done_o) stray = 1;
        end
        n_tests++;
        if (stray !== 1'b0) begin
            n_fail++; $display("FAIL hs_ignored_start: activity=%0b, required 0", stray);
        end
        n_tests++;
        if (result_o !== exp) begin
            n_fail++; $display("FAIL hs_result_hold: got %h, required %h", result_o, exp);
        end
    endtask

    task automatic test_flush();
        bit got, busy_gap, overlap, after_bad, stray;
        int lat;
        logic [XLEN-1:0] res, exp;
        @(negedge clk);
        exp_q.push_back(32'd5);
        issue(3'd7, 32'd5, 32'd0);
        wait_done(got, lat, res, busy_gap, overlap, after_bad);
        exp = exp_q.pop_front();
        n_tests++;
        if (!got || res !== exp) begin
            n_fail++; $display("FAIL flush_setup: done=%0b result %h, required %h", got, res, exp);
        end
        @(negedge clk);
        issue(3'd0, 32'd7, 32'd9);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 9) flush_i = 1'b1;
        end
        flush_i = 1'b0;
        n_tests++;
        if ({busy_o, state_o} !== 4'b0_000) begin
            n_fail++; $display("FAIL flush_abort: busy=%0b state=%0d, required busy 0 state 0", busy_o, state_o);
        end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_o || done_o) stray = 1;
        end
        n_tests++;
        if (stray !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_done: activity=%0b, required 0", stray);
        end
        n_tests++;
        if (result_o !== exp) begin
            n_fail++; $display("FAIL flush_result_hold: got %h, required %h", result_o, exp);
        end
        funct3_i = 3'd5; a_i = 32'd100; b_i = 32'd7;
        start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        stray = busy_o || (state_o != 3'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_o || done_o) stray = 1;
        end
        n_tests++;
        if (stray !== 1'b0) begin
            n_fail++; $display("FAIL flush_start_same_cycle: activity=%0b, required 0", stray);
        end
        n_tests++;
        if (result_o !== exp) begin
            n_fail++; $display("FAIL flush_start_result: got %h, required %h", result_o, exp);
        end
    endtask

    task automatic test_reset_midcalc();
        bit got, busy_gap, overlap, after_bad;
        int lat;
        logic [XLEN-1:0] res, exp;
        @(negedge clk);
        issue(3'd5, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({busy_o, done_o, state_o} !== 5'b00_000) begin
            n_fail++; $display("FAIL rst_mid_flags: busy=%0b done=%0b state=%0d, required 0 0 0", busy_o, done_o, state_o);
        end
        n_tests++;
        if (result_o !== '0) begin
            n_fail++; $display("FAIL rst_mid_result: got %h, required 0", result_o);
        end
        exp_q.push_back(32'hFFFF_FFEB);
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        wait_done(got, lat, res, busy_gap, overlap, after_bad);
        exp = exp_q.pop_front();
        n_tests++;
        if (!got || lat != LAT_NORM || res !== exp) begin
            n_fail++; $display("FAIL rst_then_start: done=%0b cycle %0d result %h, required cycle %0d result %h", got, lat, res, LAT_NORM, exp);
        end
    endtask

    task automatic test_back_to_back();
        bit got, busy_gap, overlap, after_bad;
        int lat;
        logic [XLEN-1:0] res, exp;
        @(negedge clk);
        exp_q.push_back(32'hFFFF_FFFE);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(got, lat, res, busy_gap, overlap, after_bad);
        exp = exp_q.pop_front();
        n_tests++;
        if (!got || lat != LAT_NORM || res !== exp) begin
            n_fail++; $display("FAIL b2b_first: done=%0b cycle %0d result %h, required cycle %0d result %h", got, lat, res, LAT_NORM, exp);
        end
        // Issued right away: start lands on the first IDLE edge after DONE.
        exp_q.push_back(32'd2);
        issue(3'd7, 32'd100, 32'd7);
        wait_done(got, lat, res, busy_gap, overlap, after_bad);
        exp = exp_q.pop_front();
        n_tests++;
        if (!got || lat != LAT_NORM || res !== exp) begin
            n_fail++; $display("FAIL b2b_second: done=%0b cycle %0d result %h, required cycle %0d result %h", got, lat, res, LAT_NORM, exp);
        end
    endtask

    task automatic test_random();
        bit got, busy_gap, overlap, after_bad;
        int lat, lat_exp;
        logic [2:0] op;
        logic [XLEN-1:0] a, b, res, exp;
        for (int k = 0; k < 16; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 4) == 0) b = '0;
            if ($urandom_range(0, 5) == 0) begin a = MIN_INT; b = '1; end
            lat_exp = LAT_NORM;
            if (op[2] && b == '0) lat_exp = LAT_FAST;
            if ((op == 3'd4 || op == 3'd6) && a == MIN_INT && b == '1) lat_exp = LAT_FAST;
            @(negedge clk);
            exp_q.push_back(ref_model(op, a, b));
            issue(op, a, b);
            wait_done(got, lat, res, busy_gap, overlap, after_bad);
            exp = exp_q.pop_front();
            n_tests++;
            if (!got || lat != lat_exp) begin
                n_fail++; $display("FAIL rand_latency[%0d] op=%0d: done=%0b at cycle %0d, required cycle %0d", k, op, got, lat, lat_exp);
            end
            n_tests++;
            if (res !== exp) begin
                n_fail++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h, required %h", k, op, a, b, res, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_handshake();
        test_flush();
        test_reset_midcalc();
        test_back_to_back();
        test_random();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
